instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH_B, default 32: PC and instruction width.
REQ-002 SHALL have parameter ADDR_B, default 10: instruction-memory address width, with imem_addr = pc[ADDR_B-1:0].
REQ-003 SHALL have parameter PC_STEP, default 1: PC increment per instruction (word addressing).
REQ-004 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 SHALL have parameter BUF_DEPTH, default 2, minimum 2: fetch-buffer entries.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port imem_en, output, 1 bit: read issue strobe to the synchronous ROM.
REQ-009 SHALL have port imem_addr, output, ADDR_B bits: ROM address.
REQ-010 SHALL have port imem_rdata, input, WIDTH_B bits: ROM data, valid one cycle after an issue.
REQ-011 SHALL have port redirect_valid, input, 1 bit: branch or jump taken, which flushes the unit.
REQ-012 SHALL have port redirect_pc, input, WIDTH_B bits: new fetch address.
REQ-013 SHALL have port out_valid, output, 1 bit: an instruction is presented to IF/ID.
REQ-014 SHALL have port out_ready, input, 1 bit: IF/ID accepts; deasserted means stall.
REQ-015 SHALL have port out_instr, output, WIDTH_B bits: the presented instruction.
REQ-016 SHALL have port out_pc, output, WIDTH_B bits: the address of out_instr.
REQ-017 SHALL have port out_pc_plus, output, WIDTH_B bits: out_pc + PC_STEP.
REQ-018 SHALL have port pc_debug, output, WIDTH_B bits: the next fetch PC.

Function
REQ-019 SHALL keep a fetch PC register; on each issue, fetch PC <= fetch PC + PC_STEP, modulo 2^WIDTH_B (wrap, no flag).
REQ-020 SHALL issue (imem_en=1, imem_addr=fetch PC) in a cycle iff not reset, redirect_valid=0, and count + inflight - pop < BUF_DEPTH.
REQ-021 SHALL define pop as out_valid & out_ready.
REQ-022 SHALL track each issue with a single inflight bit plus a PC tag; the next cycle, imem_rdata and the tag are written to the buffer tail if inflight is still set.
REQ-023 SHALL implement the buffer as a BUF_DEPTH-entry circular FIFO of {instr, pc}, with head and tail pointers wrapping at BUF_DEPTH and a count from 0 to BUF_DEPTH.
REQ-024 SHALL drive out_valid = (count != 0), with out_instr, out_pc and out_pc_plus taken from the head entry.
REQ-025 SHALL, when the buffer is full, never issue, so no returned data is ever dropped or overwritten; push and pop in the same cycle leave count unchanged.
REQ-026 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-027 SHALL give a latency of 2 cycles from issue to out_valid: issue in cycle N, buffer write at the end of N+1, out_valid in N+2.
REQ-028 SHALL sustain 1 instruction per cycle while out_ready=1 and BUF_DEPTH>=2.
REQ-029 SHALL, on redirect_valid=1 at an edge: set fetch PC <= redirect_pc, clear count, head, tail and inflight (the returning data is discarded), and not issue in that cycle.
REQ-030 SHALL, when redirect_valid=1 and pop occur in the same cycle, complete the transfer of the head entry to IF/ID, then apply the flush.
REQ-031 SHALL issue redirect_pc at N+1 after a redirect in cycle N, with out_valid for that instruction first in N+3.
REQ-032 SHALL, on back-to-back redirects, honour the last one; each redirect restarts the sequence in REQ-029.
REQ-033 SHALL drive pc_debug = fetch PC (the registered value).

Reset
REQ-034 SHALL, while reset=1 at an edge, set fetch PC <= RESET_PC, clear count, head, tail and inflight, and ignore redirect_valid.
REQ-035 SHALL hold out_valid=0 and imem_en=0 while reset=1.
REQ-036 SHALL reset pc_debug=RESET_PC and out_instr, out_pc and out_pc_plus to 0.
REQ-037 SHALL issue RESET_PC in the first cycle after reset deasserts, with out_valid first in the third cycle.
REQ-038 SHALL, when reset is asserted mid-operation, discard all buffered and in-flight data within one edge.

Verification
REQ-039 SHALL cover: reset, then out_ready=1 with ROM[i]=i+100 -> out_valid at cycle 2 after release; out_instr 100,101,102… every cycle; out_pc 0,1,2…; out_pc_plus 1,2,3….
REQ-040 SHALL cover: out_ready=0 for 5 cycles from cycle 4 -> count saturates at BUF_DEPTH, imem_en=0, out_* held at pc=2; on release, no gap and no duplicate instruction.
REQ-041 SHALL cover: redirect_valid=1, redirect_pc=0x40 while inflight=1 and count=2 -> stale data is dropped; next out_pc=0x40 exactly 3 cycles later, then 0x41.
REQ-042 SHALL cover: redirect together with out_valid=1 and out_ready=1 -> the head entry is accepted once, with no further old-path entries presented.
REQ-043 SHALL cover: WIDTH_B=32, redirect_pc=0xFFFFFFFF -> out_pc 0xFFFFFFFF, then 0x00000000; out_pc_plus 0x00000000; imem_addr equals the low ADDR_B bits.
REQ-044 SHALL cover: reset asserted mid-stream with count=2 -> next cycle out_valid=0 and pc_debug=RESET_PC; restart matches REQ-037.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose: fetches instructions from a synchronous ROM with one cycle read
// latency and presents them to the IF/ID stage through a small circular
// fetch buffer with a valid/ready handshake. A taken branch or jump
// (redirect) flushes the buffer and any read still in flight, then restarts
// fetching at the new address.
//
// Ports:
//   clk            single clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   imem_en        ROM read strobe (one read is issued per strobe)
//   imem_addr      ROM address, the low ADDR_B bits of the fetch PC
//   imem_rdata     ROM data, valid the cycle after a strobe
//   redirect_valid branch/jump taken, flush and restart at redirect_pc
//   redirect_pc    new fetch address
//   out_valid      an instruction is presented to IF/ID
//   out_ready      IF/ID accepts the presented instruction (low = stall)
//   out_instr      presented instruction
//   out_pc         address of out_instr
//   out_pc_plus    out_pc + PC_STEP
//   pc_debug       next fetch PC (registered)
//
// BUF_DEPTH must be at least 2 to sustain one instruction per cycle.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                 WIDTH_B   = 32,
  parameter int                 ADDR_B    = 10,
  parameter int                 PC_STEP   = 1,
  parameter logic [WIDTH_B-1:0] RESET_PC  = '0,
  parameter int                 BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_B-1:0]  imem_addr,
  input  logic [WIDTH_B-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [WIDTH_B-1:0] redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_B-1:0] out_instr,
  output logic [WIDTH_B-1:0] out_pc,
  output logic [WIDTH_B-1:0] out_pc_plus,
  output logic [WIDTH_B-1:0] pc_debug
);

  localparam int                 PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int                 CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [WIDTH_B-1:0] STEP     = WIDTH_B'(PC_STEP);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0]     DEPTH_W  = (CNT_W + 1)'(BUF_DEPTH);

  logic [WIDTH_B-1:0] fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [WIDTH_B-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [WIDTH_B-1:0] instr_q [BUF_DEPTH];
  logic [WIDTH_B-1:0] instr_d [BUF_DEPTH];
  logic [WIDTH_B-1:0] pc_q    [BUF_DEPTH];
  logic [WIDTH_B-1:0] pc_d    [BUF_DEPTH];
  logic [WIDTH_B-1:0] pcp_q   [BUF_DEPTH];
  logic [WIDTH_B-1:0] pcp_d   [BUF_DEPTH];

  logic               pop;
  logic               push;
  logic               issue;
  logic [CNT_W:0]     occupancy;
  logic [CNT_W:0]     issue_limit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign out_valid   = (count_q != '0) && !reset;
  assign pop         = out_valid && out_ready;
  assign push        = inflight_q;

  // An in-flight read already owns a buffer slot, so it is counted as
  // occupied; a pop this cycle frees one slot. Comparing against
  // BUF_DEPTH + pop avoids a subtraction that could underflow.
  assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue_limit = DEPTH_W + {{CNT_W{1'b0}}, pop};
  assign issue       = !reset && !redirect_valid && (occupancy < issue_limit);

  assign imem_en     = issue;
  assign imem_addr   = fetch_pc_q[ADDR_B-1:0];
  assign pc_debug    = fetch_pc_q;

  assign out_instr   = instr_q[head_q];
  assign out_pc      = pc_q[head_q];
  assign out_pc_plus = pcp_q[head_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    tag_d      = tag_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      instr_d[i] = instr_q[i];
      pc_d[i]    = pc_q[i];
      pcp_d[i]   = pcp_q[i];
    end

    if (redirect_valid) begin
      // Flush: the head may still be popped this cycle (IF/ID samples it),
      // but the returning read data and all buffered entries are dropped.
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        instr_d[tail_q] = imem_rdata;
        pc_d[tail_q]    = tag_q;
        pcp_d[tail_q]   = tag_q + STEP;
        tail_d          = next_ptr(tail_q);
      end
      if (pop) begin
        head_d = next_ptr(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      inflight_d = issue;
      if (issue) begin
        tag_d      = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + STEP;
      end
    end
  end

  // Buffer contents are cleared on reset so the presented outputs read as
  // zero until the first instruction arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        pcp_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= instr_d[i];
        pc_q[i]    <= pc_d[i];
        pcp_q[i]   <= pcp_d[i];
      end
    end
  end

endmodule
